// File: rtl/alarm_timer_master.sv
// alarm_timer_master: Avalon-MM master for the interval timer.
// Ports: clk/reset_n; start/use_default/period/stop/irq control inputs; address/chipselect/write_n/writedata bus outputs; readdata bus input; busy/tick/tick_count/last_status status outputs.
module alarm_timer_master #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        use_default,
    input  logic [31:0] period,
    input  logic        stop,
    input  logic        irq,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [1:0]  last_status
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        WAIT_IRQ,
        RD_STAT,
        RD_WAIT,
        CLR_STAT,
        WR_DIS
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [2:0]  addr_q, addr_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        tick_q, tick_d;
    logic [15:0] cnt_q;
    logic [1:0]  stat_q;

    logic unused_rd;
    assign unused_rd = ^readdata[15:2];

    // Next state and period latch.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    period_d = use_default ? DEFAULT_PERIOD : period;
                    state_d  = WR_PL;
                end
            end
            WR_PL:    state_d = WR_PH;
            WR_PH:    state_d = WR_CTRL;
            WR_CTRL:  state_d = WAIT_IRQ;
            WAIT_IRQ: begin
                if (stop) begin
                    state_d = WR_DIS;
                end else if (irq) begin
                    state_d = RD_STAT;
                end
            end
            RD_STAT:  state_d = RD_WAIT;
            RD_WAIT:  state_d = readdata[0] ? CLR_STAT : WAIT_IRQ;
            CLR_STAT: state_d = WAIT_IRQ;
            WR_DIS:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so
    // they are glitch-free and line up with the state they belong to.
    always_comb begin
        addr_d  = 3'd0;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        wdata_d = 16'h0000;
        busy_d  = (state_d != IDLE);
        tick_d  = 1'b0;
        unique case (state_d)
            WR_PL: begin
                addr_d  = 3'd2;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                wdata_d = period_d[15:0];
            end
            WR_PH: begin
                addr_d  = 3'd3;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                wdata_d = period_d[31:16];
            end
            WR_CTRL: begin
                addr_d  = 3'd1;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                wdata_d = 16'h0001;
            end
            RD_STAT: begin
                cs_d = 1'b1;
            end
            CLR_STAT: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                tick_d = 1'b1;
            end
            WR_DIS: begin
                addr_d = 3'd1;
                cs_d   = 1'b1;
                wn_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            period_q <= DEFAULT_PERIOD;
            addr_q   <= 3'd0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wdata_q  <= 16'h0000;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            cnt_q    <= 16'h0000;
            stat_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            if (state_q == RD_WAIT) begin
                stat_q <= readdata[1:0];
            end
            if (state_q == CLR_STAT) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign address     = addr_q;
    assign chipselect  = cs_q;
    assign write_n     = wn_q;
    assign writedata   = wdata_q;
    assign busy        = busy_q;
    assign tick        = tick_q;
    assign tick_count  = cnt_q;
    assign last_status = stat_q;

endmodule

// File: tb/tb_alarm_timer_master.sv
// tb_alarm_timer_master: directed bench for alarm_timer_master.
// Drives irq/readdata directly, then through a small interval-timer model.
module tb_alarm_timer_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        use_default = 1'b0;
    logic [31:0] period = 32'h0;
    logic        stop = 1'b0;
    logic        tb_irq = 1'b0;
    logic [15:0] tb_rd = 16'h0;
    logic        mode = 1'b0;
    logic        irq;
    logic [15:0] readdata;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic [1:0]  last_status;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alarm_timer_master #(.DEFAULT_PERIOD(32'd49)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .use_default(use_default),
        .period(period),
        .stop(stop),
        .irq(irq),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .busy(busy),
        .tick(tick),
        .tick_count(tick_count),
        .last_status(last_status)
    );

    // Interval timer slave model.
    logic [15:0] m_pl, m_ph, m_rd;
    logic [31:0] m_cnt;
    logic        m_to, m_ito, m_run;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pl <= 16'h0; m_ph <= 16'h0; m_rd <= 16'h0;
            m_cnt <= 32'h0; m_to <= 1'b0; m_ito <= 1'b0; m_run <= 1'b0;
        end else begin
            m_rd <= {14'h0, m_run, m_to};
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin m_ito <= writedata[0]; if (writedata[0]) m_run <= 1'b1; end
                    3'd2: m_pl <= writedata;
                    3'd3: begin m_ph <= writedata; m_cnt <= {writedata, m_pl}; end
                    default: ;
                endcase
            end
            if (m_run) begin
                if (m_cnt == 32'h0) begin
                    m_to  <= 1'b1;
                    m_cnt <= {m_ph, m_pl};
                end else begin
                    m_cnt <= m_cnt - 32'd1;
                end
            end
        end
    end

    assign irq      = mode ? (m_to & m_ito) : tb_irq;
    assign readdata = mode ? m_rd : tb_rd;

    function automatic logic [31:0] busv(input logic [2:0] a, input logic cs,
                                         input logic wn, input logic [15:0] d);
        return {11'h0, a, cs, wn, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cbus(input string tag, input logic [2:0] a, input logic cs,
                        input logic wn, input logic [15:0] d);
        chk(tag, busv(address, chipselect, write_n, writedata), busv(a, cs, wn, d));
    endtask

    task automatic nc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int tcyc[$];
    int n;
    logic got;

    initial begin
        // Reset state
        nc(2);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", tick_count, 0);
        chk("rst_tick", tick, 0);
        cbus("rst_bus", 0, 0, 1, 0);
        reset_n = 1'b1;
        nc(2);
        cbus("idle_bus", 0, 0, 1, 0);

        // Configure with explicit period
        start = 1; use_default = 0; period = 32'h0001_0005;
        nc(1);
        start = 0;
        cbus("cfg_pl", 2, 1, 0, 16'h0005);
        chk("cfg_busy", busy, 1);
        nc(1);
        cbus("cfg_ph", 3, 1, 0, 16'h0001);
        nc(1);
        cbus("cfg_ctrl", 1, 1, 0, 16'h0001);
        nc(1);
        cbus("wait_bus", 0, 0, 1, 0);
        chk("wait_busy", busy, 1);

        // Service a real timeout
        tb_irq = 1; tb_rd = 16'h0003;
        nc(1);
        tb_irq = 0;
        cbus("svc_rd", 0, 1, 1, 0);
        chk("svc_tick0", tick, 0);
        nc(1);
        cbus("svc_rdwait", 0, 0, 1, 0);
        chk("svc_tick1", tick, 0);
        nc(1);
        cbus("svc_clr", 0, 1, 0, 0);
        chk("svc_tick", tick, 1);
        chk("svc_cnt_pre", tick_count, 0);
        nc(1);
        chk("svc_tick_off", tick, 0);
        chk("svc_cnt", tick_count, 1);
        chk("svc_status", last_status, 2'b11);
        cbus("svc_idle", 0, 0, 1, 0);

        // Spurious interrupt
        tb_irq = 1; tb_rd = 16'h0002;
        nc(1);
        tb_irq = 0;
        cbus("sp_rd", 0, 1, 1, 0);
        nc(2);
        cbus("sp_back", 0, 0, 1, 0);
        chk("sp_tick", tick, 0);
        chk("sp_busy", busy, 1);
        chk("sp_status", last_status, 2'b10);
        nc(1);
        chk("sp_cnt", tick_count, 1);
        chk("sp_tick2", tick, 0);

        // Stop has priority over irq
        stop = 1; tb_irq = 1; tb_rd = 16'h0003;
        nc(1);
        stop = 0; tb_irq = 0;
        cbus("stop_dis", 1, 1, 0, 0);
        chk("stop_tick", tick, 0);
        nc(1);
        chk("stop_busy", busy, 0);
        cbus("stop_idle", 0, 0, 1, 0);
        chk("stop_cnt", tick_count, 1);

        // Default period; start during WR_PH ignored
        start = 1; use_default = 1;
        nc(1);
        start = 0;
        cbus("def_pl", 2, 1, 0, 16'd49);
        nc(1);
        start = 1;
        cbus("def_ph", 3, 1, 0, 0);
        nc(1);
        start = 0;
        cbus("def_ctrl", 1, 1, 0, 1);
        nc(1);
        cbus("ign_start", 0, 0, 1, 0);
        nc(1);
        cbus("ign_start2", 0, 0, 1, 0);
        chk("ign_busy", busy, 1);
        stop = 1;
        nc(1);
        stop = 0;
        cbus("def_dis", 1, 1, 0, 0);
        nc(1);
        chk("def_idle", busy, 0);

        // Reset in the middle of WR_PH
        start = 1; use_default = 0; period = 32'h1234_5678;
        nc(1);
        start = 0;
        nc(1);
        cbus("mid_ph", 3, 1, 0, 16'h1234);
        #2 reset_n = 0;
        #1;
        cbus("mid_rst_bus", 0, 0, 1, 0);
        chk("mid_rst_busy", busy, 0);
        nc(1);
        reset_n = 1;
        nc(3);
        chk("post_busy", busy, 0);
        chk("post_cnt", tick_count, 0);
        cbus("post_bus", 0, 0, 1, 0);

        // Integration with the timer model
        mode = 1;
        start = 1; use_default = 1;
        nc(1);
        start = 0;
        n = 0;
        for (int i = 0; i < 2000 && n < 10; i++) begin
            @(negedge clk);
            if (tick) begin
                tcyc.push_back(cyc);
                n++;
            end
        end
        chk("int_ticks", n, 10);
        for (int k = 1; k < tcyc.size(); k++)
            chk("int_period", tcyc[k] - tcyc[k-1], 50);
        nc(2);
        chk("int_cnt", tick_count, 10);

        // Wrap of tick_count
        force dut.cnt_q = 16'hFFFF;
        nc(1);
        release dut.cnt_q;
        nc(1);
        chk("wrap_pre", tick_count, 16'hFFFF);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (tick) got = 1;
        end
        chk("wrap_tick_seen", got, 1);
        nc(1);
        chk("wrap_cnt", tick_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_timer_master.md
# alarm_timer_master

Avalon-MM master that owns the interval timer peripheral's register interface. It programs the 32-bit period and enables the timer interrupt. It then services each timeout in hardware: wait for `irq`, read status, clear status, emit a one-cycle `tick`. It sits between the alarm-clock timekeeping logic and the 16-bit timer slave and produces the seconds-tick stream without CPU involvement.

## Interface
- `DEFAULT_PERIOD`, 32'd49999999, period loaded when `start` arrives with `use_default`=1.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to configure and run. Ignored unless `busy`=0.
- `use_default`  in  1  sampled with `start`. 1 selects `DEFAULT_PERIOD`, 0 selects `period`.
- `period`  in  32  timer load value, captured on accepted `start`.
- `stop`  in  1  request to disable the timer interrupt and return to idle.
- `irq`  in  1  timer interrupt, level.
- `address`  out  3  slave word address (0 status, 1 control, 2 period_l, 3 period_h).
- `chipselect`  out  1  slave select.
- `write_n`  out  1  active-low write strobe.
- `writedata`  out  16  write data.
- `readdata`  in  16  slave read data, registered by the slave, valid the cycle after the read address is presented.
- `busy`  out  1  high in every state except IDLE.
- `tick`  out  1  one-cycle pulse per serviced timeout.
- `tick_count`  out  16  count of ticks, wraps 0xFFFF->0x0000.
- `last_status`  out  2  `readdata[1:0]` captured in RD_WAIT.

## Operation
- Single FSM with states IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, RD_STAT, RD_WAIT, CLR_STAT, WR_DIS.
- All bus outputs, `tick` and `busy` are registered and are a function of the current state only.
- Bus is idle in IDLE, WAIT_IRQ and RD_WAIT: `chipselect`=0, `write_n`=1, `address`=0, `writedata`=0.
- State transitions and bus activity:
  - IDLE: `start`=1 -> latch the period (`DEFAULT_PERIOD` or `period`) -> WR_PL.
  - WR_PL: addr 2, cs 1, `write_n` 0, data = period[15:0] -> WR_PH.
  - WR_PH: addr 3, data = period[31:16] -> WR_CTRL.
  - WR_CTRL: addr 1, data 0x0001 (interrupt enable) -> WAIT_IRQ.
  - WAIT_IRQ: `stop`=1 -> WR_DIS (stop has priority over `irq`). Otherwise `irq`=1 -> RD_STAT. Otherwise stay.
  - RD_STAT: addr 0, cs 1, `write_n` 1 -> RD_WAIT.
  - RD_WAIT: capture `last_status`. If `readdata[0]`=1 -> CLR_STAT. Else spurious -> WAIT_IRQ with no tick.
  - CLR_STAT: addr 0, cs 1, `write_n` 0, data 0x0000. `tick`=1 this cycle. `tick_count`+1 at the end of the cycle -> WAIT_IRQ.
  - WR_DIS: addr 1, data 0x0000 -> IDLE.
- `start` outside IDLE is ignored. `stop` outside WAIT_IRQ is ignored; the next WAIT_IRQ cycle must see it again.
- `tick_count` is cleared only by reset; a new `start` does not clear it.

## Timing
- Reset values (immediate, asynchronous): state IDLE, `address`=0, `chipselect`=0, `write_n`=1, `writedata`=0, `busy`=0, `tick`=0, `tick_count`=0, `last_status`=0, latched period = `DEFAULT_PERIOD`.
- Reset mid-sequence aborts any write in progress. The bus goes idle at reset assertion. After release the FSM is in IDLE and waits for `start`; slave state is not repaired.
- `start` sampled at edge k -> WR_PL in cycle k+1, WR_PH in k+2, WR_CTRL in k+3, WAIT_IRQ from k+4. Each write lasts exactly one cycle.
- `irq` sampled high at edge j -> RD_STAT in j+1, RD_WAIT in j+2, CLR_STAT with `tick` in j+3, back in WAIT_IRQ at j+4.
- The slave clears `irq` at the edge ending CLR_STAT, so `irq` is low in the first WAIT_IRQ cycle and no double service occurs.
- Minimum service loop is 4 cycles. A timer period below 3 (period register < 3) may merge timeouts; this is not supported.

## Test plan
- Reset: assert `reset_n`=0 in mid-WR_PH -> bus idle immediately. After release: `busy`=0, `tick_count`=0, no further writes until `start`.
- Configure: `start` with `use_default`=0, `period`=0x0001_0005 -> three consecutive write cycles: (2, 0x0005), (3, 0x0001), (1, 0x0001). Then `busy`=1 with the bus idle.
- Service: in WAIT_IRQ raise `irq`, slave model returns `readdata`=0x0003 -> read at addr 0, then write 0x0000 to addr 0. `tick` high exactly 3 cycles after `irq` is sampled, `tick_count`=1, `last_status`=2'b11.
- Spurious: `irq` pulse with `readdata`=0x0002 -> no status write, `tick`=0, `tick_count` unchanged, FSM returns to WAIT_IRQ.
- Stop priority: `stop`=1 and `irq`=1 in the same WAIT_IRQ cycle -> single write (1, 0x0000), then IDLE, `busy`=0, no tick. `start` asserted during WR_PH is ignored.
- Integration with the timer slave, `DEFAULT_PERIOD` overridden to 49: `tick` every 50 cycles for 10 ticks. Preload `tick_count` to 0xFFFF -> next tick wraps it to 0x0000.
